// File: rtl/fu_gst_pkg.sv
// fu_gst_pkg: shared rounding-mode constants and default widths for the fu_gst rounding unit
package fu_gst_pkg;
   localparam int FRAC_W_DEF = 19;
   localparam int EXP_W_DEF = 13;
   typedef enum logic [1:0] {
      RM_RNE = 2'b00,
      RM_RTZ = 2'b01,
      RM_RPI = 2'b10,
      RM_RMI = 2'b11
   } rmode_e;
endpackage

// File: rtl/fu_gst_rnd19_if.sv
// fu_gst_rnd19_if: valid/ready operand and result bus of the rounding unit
interface fu_gst_rnd19_if import fu_gst_pkg::*; #(
   parameter int FRAC_W = FRAC_W_DEF,
   parameter int EXP_W = EXP_W_DEF
);
   logic flush;
   logic in_vld;
   logic in_rdy;
   logic [FRAC_W-1:0] in_frac;
   logic [EXP_W-1:0] in_exp;
   logic in_guard;
   logic in_sticky;
   logic in_sign;
   logic [1:0] in_rmode;
   logic out_vld;
   logic out_rdy;
   logic [FRAC_W-1:0] out_frac;
   logic [EXP_W-1:0] out_exp;
   logic out_ovf;
   logic out_inexact;
   modport master (
      output flush, in_vld, in_frac, in_exp, in_guard, in_sticky, in_sign, in_rmode, out_rdy,
      input in_rdy, out_vld, out_frac, out_exp, out_ovf, out_inexact
   );
   modport slave (
      input flush, in_vld, in_frac, in_exp, in_guard, in_sticky, in_sign, in_rmode, out_rdy,
      output in_rdy, out_vld, out_frac, out_exp, out_ovf, out_inexact
   );
endinterface

// File: rtl/fu_gst_rnd_dec.sv
// fu_gst_rnd_dec: round-increment decision from mode, sign, lsb, guard and sticky
module fu_gst_rnd_dec import fu_gst_pkg::*; (
   input logic [1:0] rmode,
   input logic sign,
   input logic lsb,
   input logic guard,
   input logic sticky,
   output logic inc,
   output logic inexact
);
   // increment when the mode's direction points away from the truncated value
   always_comb begin
      inexact = guard | sticky;
      inc = rmode == RM_RNE ? guard & (sticky | lsb) :
            rmode == RM_RPI ? ~sign & inexact :
            rmode == RM_RMI ? sign & inexact : 1'b0;
   end
endmodule

// File: rtl/fu_gst_rnd19.sv
// fu_gst_rnd19: two-stage pipelined fraction rounder; FU_GST_RND_SKID_EN adds a registered-ready 2-entry input skid buffer
module fu_gst_rnd19 import fu_gst_pkg::*; #(
   parameter int FRAC_W = FRAC_W_DEF,
   parameter int EXP_W = EXP_W_DEF
) (
   input logic clk,
   input logic rst,
   fu_gst_rnd19_if.slave bus
);
   typedef struct packed {
      logic [1:0] rmode;
      logic sign;
      logic guard;
      logic sticky;
      logic [EXP_W-1:0] exp;
      logic [FRAC_W-1:0] frac;
   } op_t;
   op_t in_op, feed_op, s1_op;
   logic feed_vld, feed_rdy, s1_vld, s2_vld, s1_take, s2_take;
   logic inc, inexact, carry, ovf;
   logic [FRAC_W-1:0] frac_n;
   logic [EXP_W-1:0] exp_p1, exp_n;
   assign in_op = {bus.in_rmode, bus.in_sign, bus.in_guard, bus.in_sticky, bus.in_exp, bus.in_frac};
   assign s2_take = s1_vld & (~s2_vld | bus.out_rdy);
   assign feed_rdy = ~s1_vld | s2_take;
   assign s1_take = feed_vld & feed_rdy;
`ifdef FU_GST_RND_SKID_EN
   op_t skid_q [2];
   logic [1:0] cnt, cnt_nx;
   logic rd_ptr, wr_ptr, rdy_q, push;
   assign push = bus.in_vld & rdy_q;
   assign cnt_nx = cnt + {1'b0, push} - {1'b0, s1_take};
   assign feed_vld = cnt != 2'd0;
   assign feed_op = skid_q[rd_ptr];
   assign bus.in_rdy = rdy_q;
   // skid occupancy and pointers; ready comes from a flop so out_rdy never reaches in_rdy
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         rdy_q <= 1'b1;
      end else if (bus.flush) begin
         cnt <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         rdy_q <= 1'b1;
      end else begin
         cnt <= cnt_nx;
         rd_ptr <= rd_ptr ^ s1_take;
         wr_ptr <= wr_ptr ^ push;
         rdy_q <= ~cnt_nx[1];
      end
   // skid storage needs no reset; occupancy decides what is valid
   always_ff @(posedge clk)
      if (push) skid_q[wr_ptr] <= in_op;
`else
   assign feed_vld = bus.in_vld;
   assign feed_op = in_op;
   assign bus.in_rdy = feed_rdy;
`endif
   fu_gst_rnd_dec u_dec (
      .rmode(s1_op.rmode),
      .sign(s1_op.sign),
      .lsb(s1_op.frac[0]),
      .guard(s1_op.guard),
      .sticky(s1_op.sticky),
      .inc(inc),
      .inexact(inexact)
   );
   // a carry out of the fraction renormalises to 1.000 and bumps the exponent, saturating near the top
   always_comb begin
      carry = &s1_op.frac & inc;
      exp_p1 = s1_op.exp + EXP_W'(1);
      ovf = carry & (&s1_op.exp[EXP_W-1:1]);
      frac_n = carry ? {1'b1, {(FRAC_W-1){1'b0}}} : s1_op.frac + FRAC_W'(inc);
      exp_n = ovf ? '1 : carry ? exp_p1 : s1_op.exp;
   end
   // stage 1 holds the operand while stage 2 is blocked
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_vld <= 1'b0;
         s1_op <= '0;
      end else begin
         s1_vld <= ~bus.flush & (s1_take | (s1_vld & ~s2_take));
         if (s1_take) s1_op <= feed_op;
      end
   // stage 2 is the output register; data holds whenever no new result is taken
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s2_vld <= 1'b0;
         bus.out_frac <= '0;
         bus.out_exp <= '0;
         bus.out_ovf <= 1'b0;
         bus.out_inexact <= 1'b0;
      end else begin
         s2_vld <= ~bus.flush & (s2_take | (s2_vld & ~bus.out_rdy));
         if (s2_take) begin
            bus.out_frac <= frac_n;
            bus.out_exp <= exp_n;
            bus.out_ovf <= ovf;
            bus.out_inexact <= inexact;
         end
      end
   assign bus.out_vld = s2_vld;
endmodule

// File: tb/tb_fu_gst_rnd19.sv
// tb_fu_gst_rnd19: directed self-checking bench for fu_gst_rnd19 (honours FU_GST_RND_SKID_EN latency)
module tb_fu_gst_rnd19;
   import fu_gst_pkg::*;
`ifdef FU_GST_RND_SKID_EN
   localparam int LAT = 3;
   localparam int CAP = 4;
`else
   localparam int LAT = 2;
   localparam int CAP = 2;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   logic [18:0] b_in [8] = '{19'h00001, 19'h01112, 19'h02223, 19'h03334, 19'h04445, 19'h05556, 19'h06667, 19'h07778};
   logic [18:0] b_exp [8] = '{19'h00002, 19'h01112, 19'h02224, 19'h03334, 19'h04446, 19'h05556, 19'h06668, 19'h07778};
   logic rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   fu_gst_rnd19_if #(.FRAC_W(19), .EXP_W(13)) bus ();
   fu_gst_rnd19 dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input string tag, input logic [18:0] f, input logic [12:0] e, input logic sg,
                       input logic g, input logic s, input logic [1:0] rm, input logic [18:0] wf,
                       input logic [12:0] we, input logic wo, input logic wi);
      int lat;
      int w;
      bus.out_rdy = 1'b1;
      bus.in_vld = 1'b1;
      bus.in_frac = f;
      bus.in_exp = e;
      bus.in_sign = sg;
      bus.in_guard = g;
      bus.in_sticky = s;
      bus.in_rmode = rm;
      #1;
      w = 0;
      while (!bus.in_rdy && w < 20) begin
         tick();
         w++;
      end
      tick();
      bus.in_vld = 1'b0;
      lat = 1;
      while (!bus.out_vld && lat < 10) begin
         tick();
         lat++;
      end
      check({tag, " lat"}, 64'(lat), 64'(LAT));
      check({tag, " frac"}, 64'(bus.out_frac), 64'(wf));
      check({tag, " exp"}, 64'(bus.out_exp), 64'(we));
      check({tag, " ovf"}, 64'(bus.out_ovf), 64'(wo));
      check({tag, " inexact"}, 64'(bus.out_inexact), 64'(wi));
      tick();
   endtask

   initial begin
      int i;
      int k;
      int occ;
      logic hold_v;
      logic [31:0] held;
      logic in_acc;
      logic out_acc;
      bus.flush = 1'b0;
      bus.in_vld = 1'b0;
      bus.in_frac = '0;
      bus.in_exp = '0;
      bus.in_sign = 1'b0;
      bus.in_guard = 1'b0;
      bus.in_sticky = 1'b0;
      bus.in_rmode = RM_RNE;
      bus.out_rdy = 1'b1;
      tick();
      tick();
      check("rst in_rdy", 64'(bus.in_rdy), 64'd1);
      check("rst out_vld", 64'(bus.out_vld), 64'd0);
      check("rst out_frac", 64'(bus.out_frac), 64'd0);
      check("rst out_exp", 64'(bus.out_exp), 64'd0);
      check("rst out_ovf", 64'(bus.out_ovf), 64'd0);
      check("rst out_inexact", 64'(bus.out_inexact), 64'd0);
      rst = 1'b0;
      tick();
      send("tie_odd", 19'h00001, 13'h0010, 0, 1, 0, RM_RNE, 19'h00002, 13'h0010, 0, 1);
      send("carry", 19'h7FFFF, 13'h0400, 0, 1, 1, RM_RNE, 19'h40000, 13'h0401, 0, 1);
      send("ovf_rpi", 19'h7FFFF, 13'h1FFE, 0, 1, 0, RM_RPI, 19'h40000, 13'h1FFF, 1, 1);
      send("tie_even", 19'h00002, 13'h0020, 0, 1, 0, RM_RNE, 19'h00002, 13'h0020, 0, 1);
      send("rtz", 19'h12345, 13'h0033, 1, 1, 1, RM_RTZ, 19'h12345, 13'h0033, 0, 1);
      send("rmi_neg", 19'h00FFF, 13'h0044, 1, 0, 1, RM_RMI, 19'h01000, 13'h0044, 0, 1);
      send("rmi_pos", 19'h00FFF, 13'h0055, 0, 1, 0, RM_RMI, 19'h00FFF, 13'h0055, 0, 1);
      send("exact", 19'h55555, 13'h0066, 0, 0, 0, RM_RPI, 19'h55555, 13'h0066, 0, 0);
      send("sat_max", 19'h7FFFF, 13'h1FFF, 0, 1, 1, RM_RNE, 19'h40000, 13'h1FFF, 1, 1);
      send("carry_1ffd", 19'h7FFFF, 13'h1FFD, 1, 0, 1, RM_RMI, 19'h40000, 13'h1FFE, 0, 1);
      i = 0;
      k = 0;
      occ = 0;
      hold_v = 1'b0;
      held = '0;
      bus.in_guard = 1'b1;
      bus.in_sticky = 1'b0;
      bus.in_sign = 1'b0;
      bus.in_rmode = RM_RNE;
      for (int c = 0; c < 100 && k < 8; c++) begin
         bus.out_rdy = rdy_pat[c % 4];
         bus.in_vld = i < 8;
         bus.in_frac = b_in[i % 8];
         bus.in_exp = 13'(i);
         #1;
         if (hold_v) begin
            check("hold vld", 64'(bus.out_vld), 64'd1);
            check("hold data", 64'({bus.out_exp, bus.out_frac}), 64'(held));
         end
         if (occ == CAP && !bus.out_rdy) check("full in_rdy", 64'(bus.in_rdy), 64'd0);
         in_acc = bus.in_vld & bus.in_rdy;
         out_acc = bus.out_vld & bus.out_rdy;
         if (out_acc) begin
            check("b2b data", 64'({bus.out_exp, bus.out_frac}), 64'({13'(k), b_exp[k]}));
            k++;
         end
         hold_v = bus.out_vld & ~bus.out_rdy;
         held = {bus.out_exp, bus.out_frac};
         if (in_acc) i++;
         occ += int'(in_acc) - int'(out_acc);
         tick();
      end
      check("b2b count", 64'(k), 64'd8);
      bus.in_vld = 1'b0;
      bus.out_rdy = 1'b0;
      tick();
      bus.in_vld = 1'b1;
      bus.in_frac = 19'h00123;
      tick();
      tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      bus.in_vld = 1'b0;
      bus.out_rdy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         check("flush out_vld", 64'(bus.out_vld), 64'd0);
         check("flush in_rdy", 64'(bus.in_rdy), 64'd1);
         tick();
      end
      bus.out_rdy = 1'b0;
      bus.in_vld = 1'b1;
      bus.in_frac = 19'h00321;
      bus.in_exp = 13'h0077;
      repeat (4) tick();
      bus.in_vld = 1'b0;
      #3;
      check("pre-rst out_vld", 64'(bus.out_vld), 64'd1);
      rst = 1'b1;
      #1;
      check("arst out_vld", 64'(bus.out_vld), 64'd0);
      check("arst out_frac", 64'(bus.out_frac), 64'd0);
      check("arst out_exp", 64'(bus.out_exp), 64'd0);
      check("arst out_ovf", 64'(bus.out_ovf), 64'd0);
      check("arst out_inexact", 64'(bus.out_inexact), 64'd0);
      check("arst in_rdy", 64'(bus.in_rdy), 64'd1);
      #2;
      rst = 1'b0;
      tick();
      send("post_rst", 19'h00001, 13'h0010, 0, 1, 0, RM_RNE, 19'h00002, 13'h0010, 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fu_gst_rnd19.md
FU_GST_RND19 -- requirements
Module: fu_gst_rnd19

Interface
REQ-001 SHALL have parameter FRAC_W, default 19, fraction width (bits 1..FRAC_W, bit 1 MSB).
REQ-002 SHALL have parameter EXP_W, default 13, exponent width.
REQ-003 SHALL have one clock and asynchronous active-high reset: clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 flush  in  1  synchronous kill of all in-flight operations.
REQ-006 in_vld  in  1  input operation valid.
REQ-007 in_rdy  out  1  block accepts input this cycle.
REQ-008 in_frac  in  FRAC_W  unrounded fraction.
REQ-009 in_exp  in  EXP_W  biased exponent.
REQ-010 in_guard, in_sticky, in_sign  in  1 each  guard bit, sticky bit, result sign.
REQ-011 in_rmode  in  2  00 nearest-even, 01 truncate, 10 toward +inf, 11 toward -inf.
REQ-012 out_vld  out  1  result valid.
REQ-013 out_rdy  in  1  consumer accepts result.
REQ-014 out_frac  out  FRAC_W  rounded fraction; out_exp  out  EXP_W  adjusted exponent.
REQ-015 out_ovf, out_inexact  out  1 each  exponent overflow, rounding inexact.

Function
REQ-016 Transfer in: in_vld & in_rdy; transfer out: out_vld & out_rdy; no transfer SHALL be lost or duplicated.
REQ-017 Stage 1 SHALL register inputs and compute inc: rmode 00 -> guard & (sticky | frac[FRAC_W]); 01 -> 0; 10 -> ~sign & (guard|sticky); 11 -> sign & (guard|sticky).
REQ-018 Stage 2 SHALL register frac+inc modulo 2^FRAC_W, out_inexact = guard|sticky.
REQ-019 Carry-out (frac all ones & inc) SHALL give out_frac = 1 followed by zeros (bit 1 set) and out_exp = in_exp+1.
REQ-020 If in_exp+1 on carry-out reaches all ones, out_exp SHALL saturate at all ones and out_ovf = 1; otherwise out_ovf = 0.
REQ-021 Latency SHALL be 2 cycles from in transfer to out_vld with out_rdy held high; throughput one per cycle.
REQ-022 With out_rdy low, out_* SHALL hold stable; pipeline SHALL stall back to in_rdy, no bubble collapse lost.
REQ-023 Bubbles SHALL collapse: a stage advances whenever its successor is empty or draining.
REQ-024 flush SHALL clear all stage valids next edge; an in transfer in the flush cycle is discarded; flush wins over simultaneous in_vld.
REQ-025 Output data fields SHALL be don't-care but deterministic when out_vld = 0.

Reset
REQ-026 rst SHALL asynchronously clear all valid bits; out_vld = 0, out_frac = 0, out_exp = 0, out_ovf = 0, out_inexact = 0.
REQ-027 in_rdy SHALL be 1 during and after reset; reset mid-operation discards all in-flight work.

Configuration
REQ-028 Macro FU_GST_RND_SKID_EN defined: in_rdy SHALL be driven from a register (2-entry input skid buffer), no combinational out_rdy-to-in_rdy path; latency 3 cycles.
REQ-029 Macro undefined: no skid buffer; in_rdy = ~s1_vld | s1 advancing (combinational from out_rdy); latency 2.

Structure
REQ-030 Shared package fu_gst_pkg SHALL hold rounding-mode constants (RM_RNE, RM_RTZ, RM_RPI, RM_RMI) and FRAC_W/EXP_W defaults.
REQ-031 Round-decision logic SHALL be sub-module fu_gst_rnd_dec (combinational: rmode, sign, lsb, guard, sticky -> inc, inexact).

Verification
REQ-032 frac=0x00001, g=1, s=0, rmode=00, out_rdy=1 -> after 2 cycles out_frac=0x00002, inexact=1 (tie, odd lsb rounds up).
REQ-033 frac=0x7FFFF, exp=0x0400, g=1, s=1, rmode=00 -> out_frac=0x40000, out_exp=0x0401, ovf=0.
REQ-034 frac=0x7FFFF, exp=0x1FFE, rmode=10, sign=0, g=1 -> out_exp=0x1FFF, out_ovf=1.
REQ-035 Back-to-back 8 ops, out_rdy toggled 1,0,0,1 -> all 8 results in order, unchanged while stalled, in_rdy low when full.
REQ-036 Two ops in flight, flush=1 with in_vld=1 -> no out_vld next 3 cycles, in_rdy=1.
REQ-037 rst asserted mid-stream asynchronously -> out_vld=0 immediately, all outputs zero, first post-reset op returns at normal latency.
